// File: rtl/a1csa_operand_sequencer.sv
// a1csa_operand_sequencer
//   Streams two N-bit operands and a carry-in in from a W-bit valid/ready
//   channel, holds them on the adder inputs, waits for the adder to settle,
//   captures {cout,s} and streams the sum back out least-significant word first.
//   Optional build macro: A1CSA_SEQ_SETTLE_EN stretches the settle wait to
//   SETTLE_CYCLES cycles for a multicycle adder. Without it the wait is one cycle.
module a1csa_operand_sequencer #(
    parameter int N             = 256,
    parameter int W             = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_cin,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_cout
);

    localparam int WORDS = N / W;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
`ifdef A1CSA_SEQ_SETTLE_EN
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
`else
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(0);
`endif

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SETTLE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t          state_q,      state_d;
    logic [CW-1:0]   word_cnt_q,   word_cnt_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [N-1:0]    add_a_q,      add_a_d;
    logic [N-1:0]    add_b_q,      add_b_d;
    logic            add_cin_q,    add_cin_d;
    logic [N-1:0]    res_q,        res_d;
    logic            cout_q,       cout_d;
    logic [31:0]     bit_base_s;
    logic            last_word_s;

    assign bit_base_s  = 32'(word_cnt_q) * 32'(W);
    assign last_word_s = (word_cnt_q == LAST_WORD);

    // Next-state logic: operand assembly, settle countdown, result drain.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        settle_cnt_d = settle_cnt_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_cin_d    = add_cin_q;
        res_d        = res_q;
        cout_d       = cout_q;
        case (state_q)
            LOAD_A: begin
                if (in_valid) begin
                    add_a_d[bit_base_s +: W] = in_data;
                    if (word_cnt_q == CW'(0)) begin
                        add_cin_d = in_cin;
                    end else begin
                        add_cin_d = add_cin_q;
                    end
                    if (last_word_s) begin
                        word_cnt_d = CW'(0);
                        state_d    = LOAD_B;
                    end else begin
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = LOAD_A;
                end
            end
            LOAD_B: begin
                if (in_valid) begin
                    add_b_d[bit_base_s +: W] = in_data;
                    if (last_word_s) begin
                        word_cnt_d   = CW'(0);
                        settle_cnt_d = SETTLE_LOAD;
                        state_d      = SETTLE;
                    end else begin
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = LOAD_B;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SW'(0)) begin
                    res_d      = add_s;
                    cout_d     = add_cout;
                    word_cnt_d = CW'(0);
                    state_d    = DRAIN;
                end else begin
                    settle_cnt_d = settle_cnt_q - SW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (last_word_s) begin
                        word_cnt_d = CW'(0);
                        state_d    = LOAD_A;
                    end else begin
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d    = LOAD_A;
                word_cnt_d = CW'(0);
            end
        endcase
    end

    // State register with synchronous reset clearing operands and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD_A;
            word_cnt_q   <= CW'(0);
            settle_cnt_q <= SW'(0);
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_cin_q    <= 1'b0;
            res_q        <= '0;
            cout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_cin_q    <= add_cin_d;
            res_q        <= res_d;
            cout_q       <= cout_d;
        end
    end

    // Outputs decoded from registered state only; stable under backpressure.
    always_comb begin
        in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
        out_valid = (state_q == DRAIN);
        out_last  = out_valid && last_word_s;
        out_data  = out_valid ? res_q[bit_base_s +: W] : {W{1'b0}};
        out_cout  = out_last ? cout_q : 1'b0;
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;

endmodule

// File: tb/tb_a1csa_operand_sequencer.sv
// Directed + random bench for a1csa_operand_sequencer with a behavioural adder.
module tb_a1csa_operand_sequencer;

    localparam int N     = 256;
    localparam int W     = 32;
    localparam int WORDS = N / W;
    localparam int SC    = 3;
    localparam int NP    = N + 1;
`ifdef A1CSA_SEQ_SETTLE_EN
    localparam int EXP_LAT = SC;
`else
    localparam int EXP_LAT = 1;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_cin;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_cout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    a1csa_operand_sequencer #(.N(N), .W(W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_cout(out_cout)
    );

    // Behavioural adder standing in for the carry select adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] s;
        logic         cout;
        int           stall;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one word; returns just after the negedge following acceptance.
    task automatic send_word(input logic [W-1:0] d, input logic c);
        int n = 0;
        in_data  = d;
        in_cin   = c;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", NP'(in_ready), NP'(1));
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic c, input int gaps, input int nb);
        for (int i = 0; i < WORDS; i++) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(a[i*W +: W], (i == 0) ? c : 1'($urandom));
        end
        for (int i = 0; i < nb; i++) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(b[i*W +: W], 1'($urandom));
        end
    endtask

    // Collect one result, checking handshake rules, stability and flags.
    task automatic recv_op(input int stall, output logic [N-1:0] res,
                           output logic cout, output int lat);
        int n = 0, idx = 0, p = 0;
        int inr_err = 0, last_err = 0, stab_err = 0;
        logic held = 1'b0;
        logic [W-1:0] hd;
        logic hl, hc, rdy;
        res = '0; cout = 1'b0; lat = -1; hd = '0; hl = 1'b0; hc = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) inr_err++;
            @(negedge clk);
            n++;
        end
        lat = cyc - acc_cyc;
        while (idx < WORDS && n < 1000 && out_valid) begin
            if (in_ready) inr_err++;
            if (held && (out_data !== hd || out_last !== hl || out_cout !== hc)) stab_err++;
            rdy = (stall != 0) ? (p % 3 == 0) : 1'b1;
            p++;
            out_ready = rdy;
            if (rdy) begin
                res[idx*W +: W] = out_data;
                if (out_last !== (idx == WORDS - 1)) last_err++;
                if (idx == WORDS - 1) cout = out_cout;
                else if (out_cout !== 1'b0) last_err++;
                idx++;
                held = 1'b0;
            end else begin
                held = 1'b1; hd = out_data; hl = out_last; hc = out_cout;
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        chk("words_drained", NP'(idx), NP'(WORDS));
        chk("in_ready_busy", NP'(inr_err), NP'(0));
        chk("last_cout_flags", NP'(last_err), NP'(0));
        chk("stall_stable", NP'(stab_err), NP'(0));
        chk("post_drain_out_valid", NP'(out_valid), NP'(0));
        chk("post_drain_in_ready", NP'(in_ready), NP'(1));
    endtask

    initial begin
        logic [N-1:0] res, ra, rb;
        logic         rc, rcin;
        int           lat;

        vecs[0] = '{a: {N{1'b1}},   b: '0,           cin: 1'b1, s: '0,          cout: 1'b1, stall: 0};
        vecs[1] = '{a: 256'd1,      b: 256'd1,       cin: 1'b0, s: 256'd2,      cout: 1'b0, stall: 0};
        vecs[2] = '{a: {N{1'b1}},   b: '0,           cin: 1'b1, s: '0,          cout: 1'b1, stall: 1};
        vecs[3] = '{a: {64{4'h5}},  b: {64{4'hA}},   cin: 1'b0, s: {N{1'b1}},   cout: 1'b0, stall: 1};
        vecs[4] = '{a: {N{1'b1}},   b: {N{1'b1}},    cin: 1'b1, s: {N{1'b1}},   cout: 1'b1, stall: 0};
        vecs[5] = '{a: '0,          b: '0,           cin: 1'b0, s: '0,          cout: 1'b0, stall: 0};
        vecs[6] = '{a: {1'b1, 255'd0}, b: {1'b1, 255'd0}, cin: 1'b0, s: '0,     cout: 1'b1, stall: 1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  NP'(in_ready),  NP'(1));
        chk("rst_out_valid", NP'(out_valid), NP'(0));
        chk("rst_out_data",  NP'(out_data),  NP'(0));
        chk("rst_out_last",  NP'(out_last),  NP'(0));
        chk("rst_out_cout",  NP'(out_cout),  NP'(0));
        chk("rst_add_a",     NP'(add_a),     NP'(0));
        chk("rst_add_b",     NP'(add_b),     NP'(0));
        chk("rst_add_cin",   NP'(add_cin),   NP'(0));

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            send_op(vecs[v].a, vecs[v].b, vecs[v].cin, 0, WORDS);
            recv_op(vecs[v].stall, res, rc, lat);
            chk($sformatf("vec%0d_sum", v),  NP'(res), NP'(vecs[v].s));
            chk($sformatf("vec%0d_cout", v), NP'(rc),  NP'(vecs[v].cout));
            if (v == 0) chk("settle_latency", NP'(lat), NP'(EXP_LAT));
        end

        // Reset after three b words discards the partial operand.
        send_op({N{1'b1}}, {N{1'b1}}, 1'b1, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready",  NP'(in_ready),  NP'(1));
        chk("midrst_out_valid", NP'(out_valid), NP'(0));
        chk("midrst_add_a",     NP'(add_a),     NP'(0));
        chk("midrst_add_cin",   NP'(add_cin),   NP'(0));
        send_op({64{4'h5}}, {64{4'hA}}, 1'b1, 0, WORDS);
        recv_op(0, res, rc, lat);
        chk("midrst_sum",  NP'(res), NP'(0));
        chk("midrst_cout", NP'(rc),  NP'(1));

        // Random operands with input gaps and random backpressure.
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < WORDS; i++) begin
                ra[i*W +: W] = $urandom;
                rb[i*W +: W] = $urandom;
            end
            rcin = 1'($urandom);
            send_op(ra, rb, rcin, 1, WORDS);
            recv_op(int'($urandom_range(0, 1)), res, rc, lat);
            chk($sformatf("rand%0d_result", k), {rc, res},
                {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rcin});
            chk($sformatf("rand%0d_latency", k), NP'(lat), NP'(EXP_LAT));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
